// File: rtl/hopf_update_scheduler_pkg.sv
// Shared definitions for the Hopf oscillator front-end: datapath defaults,
// sequencer state encoding and the noise LFSR feedback mask.
package hopf_pkg;

  localparam int HOPF_WIDTH = 18;
  localparam int HOPF_FRAC  = 14;

  localparam int LFSR_W = 23;
  // Right-shifting Galois form of x^23 + x^18 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h420000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } hopf_state_t;

endpackage

// File: rtl/hopf_update_scheduler_if.sv
// Configuration channel into the scheduler. valid/ready: a transfer happens on
// any rising clk edge where cfg_valid and cfg_ready are both 1; the master
// holds the payload stable while cfg_valid is high and ready is low.
interface hopf_update_scheduler_if
  import hopf_pkg::*;
#(
  parameter int WIDTH = HOPF_WIDTH
);

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic signed [WIDTH-1:0] cfg_mu_dt;
  logic signed [WIDTH-1:0] cfg_omega_dt;
  logic signed [WIDTH-1:0] cfg_noise_amp;

  modport master (
    output cfg_valid,
    output cfg_mu_dt,
    output cfg_omega_dt,
    output cfg_noise_amp,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mu_dt,
    input  cfg_omega_dt,
    input  cfg_noise_amp,
    output cfg_ready
  );

endinterface

// File: rtl/hopf_update_scheduler_noise_lfsr.sv
// 23-bit Galois LFSR for the oscillator noise source; steps once per advance
// pulse and never starts from the all-zero lock-up state.
module hopf_noise_lfsr
  import hopf_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 23'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_next;

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]};
    if (lfsr_q[0]) begin
      lfsr_next = lfsr_next ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SAFE_SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/hopf_update_scheduler.sv
// Update-rate sequencer for one stochastic Hopf oscillator: clock divider,
// warm-up/run phases, scaled LFSR noise and boundary-aligned parameter updates.
module hopf_update_scheduler
  import hopf_pkg::*;
#(
  parameter int                WIDTH        = HOPF_WIDTH,
  parameter int                FRAC         = HOPF_FRAC,
  parameter int                CLK_DIV      = 25000,
  parameter int                WARMUP_TICKS = 4000,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 23'h1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  hopf_update_scheduler_if.slave  cfg,
  output logic                    osc_clk_en,
  output logic signed [WIDTH-1:0] mu_dt,
  output logic signed [WIDTH-1:0] omega_dt,
  output logic signed [WIDTH-1:0] noise_x,
  output logic [1:0]              state,
  output logic [15:0]             tick_count
);

  localparam int                      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]             WARM_LAST = 16'(WARMUP_TICKS);
  localparam logic signed [WIDTH-1:0] AMP_MAX   = WIDTH'(1 << FRAC);

  hopf_state_t state_q;
  hopf_state_t state_d;

  logic [DIV_W-1:0] div_q;
  logic [15:0]      tick_q;
  logic [15:0]      tick_inc;
  logic             active;
  logic             strobe;
  logic             leaving;

  logic                    pending_q;
  logic                    cfg_fire;
  logic                    apply_cfg;
  logic signed [WIDTH-1:0] sh_mu_q;
  logic signed [WIDTH-1:0] sh_omega_q;
  logic signed [WIDTH-1:0] sh_amp_q;
  logic signed [WIDTH-1:0] amp_q;
  logic signed [WIDTH-1:0] amp_clamped;

  logic [LFSR_W-1:0]         lfsr_q;
  logic signed [WIDTH-1:0]   sample;
  logic signed [2*WIDTH-1:0] sample_ext;
  logic signed [2*WIDTH-1:0] amp_ext;
  logic signed [WIDTH-1:0]   scaled;

  assign active     = (state_q != ST_IDLE);
  assign strobe     = active && (div_q == DIV_LAST);
  assign leaving    = active && !enable;
  assign tick_inc   = (tick_q == 16'hFFFF) ? tick_q : tick_q + 16'd1;
  assign osc_clk_en = strobe;
  assign state      = state_q;
  assign tick_count = tick_q;

  // Sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = (WARMUP_TICKS == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (strobe && (tick_inc == WARM_LAST)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider and tick counter; both restart from zero on every entry from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (!active || leaving) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (strobe) begin
      div_q  <= '0;
      tick_q <= tick_inc;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  hopf_noise_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (strobe),
    .lfsr_q  (lfsr_q)
  );

  // Amplitude is capped at unity gain so the scaled sample always fits WIDTH.
  always_comb begin
    amp_clamped = cfg.cfg_noise_amp;
    if (cfg.cfg_noise_amp[WIDTH-1]) begin
      amp_clamped = '0;
    end else if (cfg.cfg_noise_amp > AMP_MAX) begin
      amp_clamped = AMP_MAX;
    end
  end

  assign sample     = WIDTH'(lfsr_q);
  assign sample_ext = {{WIDTH{sample[WIDTH-1]}}, sample};
  assign amp_ext    = {{WIDTH{amp_q[WIDTH-1]}}, amp_q};
  assign scaled     = WIDTH'((sample_ext * amp_ext) >>> FRAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      noise_x <= '0;
    end else if (!active || leaving) begin
      noise_x <= '0;
    end else if (strobe) begin
      noise_x <= (state_q == ST_RUN) ? scaled : '0;
    end
  end

  // One-deep shadow: accepted in any state, applied in IDLE or on a strobe edge,
  // where the oscillator still samples the previous values.
  assign cfg.cfg_ready = !pending_q;
  assign cfg_fire      = cfg.cfg_valid && !pending_q;
  assign apply_cfg     = pending_q && (!active || strobe);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= 1'b0;
      sh_mu_q    <= '0;
      sh_omega_q <= '0;
      sh_amp_q   <= '0;
      mu_dt      <= '0;
      omega_dt   <= '0;
      amp_q      <= '0;
    end else if (cfg_fire) begin
      pending_q  <= 1'b1;
      sh_mu_q    <= cfg.cfg_mu_dt;
      sh_omega_q <= cfg.cfg_omega_dt;
      sh_amp_q   <= amp_clamped;
    end else if (apply_cfg) begin
      pending_q <= 1'b0;
      mu_dt     <= sh_mu_q;
      omega_dt  <= sh_omega_q;
      amp_q     <= sh_amp_q;
    end
  end

endmodule
